// File: rtl/kyber_noise_sampler.sv
// Multi-lane xorshift32 noise sampler: bounded-uniform (rejection) or centered
// binomial coefficients, LANES per valid/ready beat, one polynomial per start.

module kyber_noise_sampler #(
    parameter int          LANES     = 4,
    parameter int          OUT_W     = 8,
    parameter int          MIN_VALUE = -17,
    parameter int          MAX_VALUE = 17,
    parameter int          ETA       = 2,
    parameter int          N_COEFFS  = 256,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seed_load,
    input  logic [31:0]            seed,
    input  logic                   start,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   busy,
    output logic                   done
);
    localparam int          BEATS = N_COEFFS / LANES;
    localparam int          CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int          RANGE = MAX_VALUE - MIN_VALUE + 1;
    localparam int          K     = (RANGE == 1) ? 1 : $clog2(RANGE);
    localparam int          HI    = (1 << (OUT_W - 1)) - 1;
    localparam int          LO    = -(1 << (OUT_W - 1));
    localparam logic [31:0] GOLD  = 32'h9E37_79B9;

    if ((N_COEFFS % LANES) != 0 || MIN_VALUE > MAX_VALUE || MIN_VALUE < LO ||
        MAX_VALUE > HI || ETA > HI || 2 * ETA > 32) begin : g_bad_cfg
        $error("kyber_noise_sampler: invalid parameter set");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state, state_nxt;
    logic                          run, fire, last, flush, load, mode_q;
    logic [CNT_W-1:0]              beat_cnt;
    logic [31:0]                   seed_eff;
    logic [LANES-1:0]              full;
    logic [LANES-1:0][OUT_W-1:0]   hold;

    assign run      = (state == RUN);
    assign fire     = out_valid & out_ready;
    assign last     = (beat_cnt == CNT_W'(BEATS - 1));
    assign flush    = fire & last;
    assign load     = ~run & seed_load;
    assign seed_eff = (seed == 32'd0) ? SEED : seed;
    assign out_data = hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // seed_load wins over start in the same IDLE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !seed_load) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        out_valid = (state == RUN) & (&full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            beat_cnt <= '0;
            done     <= 1'b0;
        end else begin
            if (state == IDLE && start && !seed_load) mode_q <= mode;
            if (flush)     beat_cnt <= '0;
            else if (fire) beat_cnt <= beat_cnt + 1'b1;
            done <= flush;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [31:0] MIX = 32'(i) * GOLD;

        logic [31:0]      x, t0, t1, r;
        logic [K-1:0]     v;
        logic             draw, accept, full_q;
        logic [OUT_W-1:0] coeff, hold_q;
        int               pa, pb;

        assign t0   = x ^ (x << 13);
        assign t1   = t0 ^ (t0 >> 17);
        assign r    = t1 ^ (t1 << 5);
        assign v    = r[K-1:0];
        assign draw = run & (~full_q | fire);

        always_comb begin
            pa = 0;
            pb = 0;
            for (int j = 0; j < ETA; j++) begin
                pa += int'(r[j]);
                pb += int'(r[ETA+j]);
            end
            if (mode_q) begin
                accept = 1'b1;
                coeff  = OUT_W'(pa - pb);
            end else begin
                accept = (32'(v) < 32'(RANGE));
                coeff  = OUT_W'(int'(32'(v)) + MIN_VALUE);
            end
        end

        // a rejected draw still advances the generator but leaves the hold alone
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x      <= SEED ^ MIX;
                hold_q <= '0;
                full_q <= 1'b0;
            end else begin
                if (load)      x <= seed_eff ^ MIX;
                else if (draw) x <= r;
                if (flush) begin
                    hold_q <= '0;
                    full_q <= 1'b0;
                end else if (draw && accept) begin
                    hold_q <= coeff;
                    full_q <= 1'b1;
                end else if (fire) begin
                    full_q <= 1'b0;
                end
            end
        end

        assign hold[i] = hold_q;
        assign full[i] = full_q;
    end

endmodule

// File: tb/tb_kyber_noise_sampler.sv
// Scoreboard bench for kyber_noise_sampler: a per-lane sequence model predicts
// every beat and the polynomial duration; a negedge monitor pops and compares.

module tb_kyber_noise_sampler;
    localparam int          LANES = 4;
    localparam int          OUT_W = 8;
    localparam int          MIN_V = -17;
    localparam int          MAX_V = 17;
    localparam int          ETA   = 2;
    localparam int          NCOEF = 256;
    localparam int          BEATS = NCOEF / LANES;
    localparam int          RANGE = MAX_V - MIN_V + 1;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam logic [31:0] GOLD  = 32'h9E37_79B9;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   seed_load = 1'b0;
    logic [31:0]            seed = 32'd0;
    logic                   start = 1'b0;
    logic                   mode = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   out_valid, busy, done;
    logic [LANES*OUT_W-1:0] out_data;

    kyber_noise_sampler #(
        .LANES(LANES), .OUT_W(OUT_W), .MIN_VALUE(MIN_V), .MAX_VALUE(MAX_V),
        .ETA(ETA), .N_COEFFS(NCOEF), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .start(start), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]            mx [LANES];
    logic [LANES*OUT_W-1:0] exp_q [$];
    bit                     cur_mode;
    int                     poly_fires = 0;
    int                     done_cnt = 0;
    bit                     seen [RANGE];
    bit                     prev_stall = 1'b0;
    logic [LANES*OUT_W-1:0] prev_data;
    logic [LANES*OUT_W-1:0] first_data;
    logic [LANES*OUT_W-1:0] e_word;
    logic signed [OUT_W-1:0] lane_v;
    int                     vv;
    bit                     rng_ok;

    function automatic logic [31:0] xs(input logic [31:0] x);
        x ^= x << 13;
        x ^= x >> 17;
        x ^= x << 5;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_seed(input logic [31:0] s);
        for (int i = 0; i < LANES; i++) mx[i] = s ^ (32'(i) * GOLD);
    endtask

    // Lane i, beat k = the k-th accepted draw of lane i; one extra draw happens
    // on the final fire. Duration = sum over beats of the slowest lane's draws.
    task automatic model_poly(input bit m, output int need);
        int c [LANES][BEATS];
        int d [LANES][BEATS];
        logic [31:0] r;
        logic [LANES*OUT_W-1:0] w;
        int u, mxd;
        bit acc;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < BEATS; k++) begin
                d[i][k] = 0;
                acc = 1'b0;
                while (!acc) begin
                    r = xs(mx[i]);
                    mx[i] = r;
                    d[i][k]++;
                    if (m) begin
                        c[i][k] = $countones(r[ETA-1:0]) - $countones(r[2*ETA-1:ETA]);
                        acc = 1'b1;
                    end else begin
                        u = int'(r & 32'h3F);
                        if (u < RANGE) begin
                            c[i][k] = u + MIN_V;
                            acc = 1'b1;
                        end
                    end
                end
            end
            mx[i] = xs(mx[i]);
        end
        need = 1;
        for (int k = 0; k < BEATS; k++) begin
            w = '0;
            mxd = 0;
            for (int i = 0; i < LANES; i++) begin
                w[i*OUT_W +: OUT_W] = OUT_W'(c[i][k]);
                if (d[i][k] > mxd) mxd = d[i][k];
            end
            exp_q.push_back(w);
            need += mxd;
        end
    endtask

    task automatic do_seed(input logic [31:0] s);
        seed = s;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        model_seed((s == 32'd0) ? SEED : s);
    endtask

    task automatic run_poly(input bit m, input bit rnd, input bit meddle);
        int need, t0, n;
        cur_mode = m;
        model_poly(m, need);
        poly_fires = 0;
        mode = m;
        out_ready = rnd ? 1'($urandom % 2) : 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        n = 0;
        while (!done && n < 5000) begin
            if (meddle && n == 20) begin
                seed_load = 1'b1;
                seed = $urandom;
                start = 1'b1;
                mode = ~m;
            end else begin
                seed_load = 1'b0;
                start = 1'b0;
                mode = m;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom % 2);
            n++;
        end
        seed_load = 1'b0;
        start = 1'b0;
        check("done_seen", done, 1);
        if (!rnd) check("poly_cycles", cyc - t0, need);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_data", out_data, 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", out_data);
                end else begin
                    e_word = exp_q.pop_front();
                    check("beat_data", out_data, e_word);
                end
                if (poly_fires == 0) first_data = out_data;
                rng_ok = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    lane_v = out_data[i*OUT_W +: OUT_W];
                    vv = lane_v;
                    if (cur_mode) begin
                        if (vv < -ETA || vv > ETA) rng_ok = 1'b0;
                    end else if (vv < MIN_V || vv > MAX_V) begin
                        rng_ok = 1'b0;
                    end else begin
                        seen[vv - MIN_V] = 1'b1;
                    end
                end
                check("range", rng_ok, 1);
                poly_fires++;
            end
            if (done) begin
                check("fires_per_poly", poly_fires, BEATS);
                done_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        int nseen, dc, n;
        logic [31:0] rs;

        // reset and idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_seed(SEED);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_data", out_data, 0);
        end

        // CBD from seed 1, back-to-back
        do_seed(32'd1);
        run_poly(1'b1, 1'b0, 1'b0);
        check("cbd_first_lane0", first_data[OUT_W-1:0], 8'd1);

        // uniform from seed 1, then value coverage over 20 polys
        for (int v = 0; v < RANGE; v++) seen[v] = 1'b0;
        do_seed(32'd1);
        run_poly(1'b0, 1'b0, 1'b0);
        check("uni_first_lane0", first_data[OUT_W-1:0], 8'd16);
        for (int p = 0; p < 19; p++) run_poly(1'b0, 1'b0, 1'b0);
        nseen = 0;
        for (int v = 0; v < RANGE; v++) nseen += int'(seen[v]);
        check("uni_all_values", nseen, RANGE);

        // CBD under random backpressure
        do_seed(32'd1);
        run_poly(1'b1, 1'b1, 1'b0);

        // zero seed, repeated seed, seed_load+start in the same cycle, meddling in RUN
        do_seed(32'd0);
        run_poly(1'b1, 1'b0, 1'b0);
        rs = $urandom;
        do_seed(rs);
        run_poly(1'b0, 1'b0, 1'b1);
        do_seed(rs);
        run_poly(1'b0, 1'b1, 1'b1);
        seed = rs;
        seed_load = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        start = 1'b0;
        model_seed(rs);
        check("load_beats_start", busy, 0);
        run_poly(1'b1, 1'b0, 1'b1);

        // reset mid-RUN
        rst_n = 1'b0;
        #1;
        model_seed(SEED);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_mode = 1'b1;
        model_poly(1'b1, n);
        poly_fires = 0;
        mode = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (poly_fires < 10 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_fires", poly_fires, 10);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_busy", busy, 0);
        check("async_data", out_data, 0);
        check("async_done", done, 0);
        exp_q.delete();
        model_seed(SEED);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt, dc);
        run_poly(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
